// File: rtl/hazard_ctrl_pkg.sv
// Shared DHRUT-V pipeline definitions: hazard FSM states, register-address
// constants and counter widths used by the hazard controller.
package dhrutv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  localparam int MCNT_W = 5;
  localparam int WCNT_W = 8;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } hz_state_t;

  // True when an ID source operand is read and names the given destination.
  function automatic logic src_hit(logic used, logic [REG_ADDR_W-1:0] rs,
                                   logic [REG_ADDR_W-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Sideband bundle between the fetch/decode/EX/MEM pipeline and the hazard
// controller: hazard sources in, stage hold/bubble controls out.
interface hazard_ctrl_if;
  import dhrutv_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_wr;
  logic                  ex_is_load;
  logic                  ex_redirect;
  logic                  ex_mdu_start;
  logic                  mem_req;
  logic                  mem_ack;

  logic stall_if;
  logic stall_id;
  logic stall_ex;
  logic stall_mem;
  logic flush_if;
  logic flush_id;
  logic flush_ex;
  logic mdu_done;
  logic mem_err;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_reg_wr,
           ex_is_load, ex_redirect, ex_mdu_start, mem_req, mem_ack,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id,
           flush_ex, mdu_done, mem_err
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_reg_wr,
           ex_is_load, ex_redirect, ex_mdu_start, mem_req, mem_ack,
    output stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id,
           flush_ex, mdu_done, mem_err
  );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves memory wait, multi-cycle MDU,
// redirect and load-use hazards in that priority order.
module hazard_ctrl
  import dhrutv_pkg::*;
#(
  parameter int MDU_LAT     = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam logic [MCNT_W-1:0] MCNT_START = MCNT_W'(MDU_LAT - 2);
  localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT);

  hz_state_t         state, state_nx;
  logic [MCNT_W-1:0] mcnt, mcnt_nx;
  logic [WCNT_W-1:0] wcnt;

  logic tout, mw, lu, mdu_stall, stall_ex_i, redir_act, lu_act;

  // A timed-out access is released exactly like an ack.
  assign tout = (wcnt == WCNT_LIMIT);
  assign mw   = hz.mem_req & ~hz.mem_ack & ~tout;

  assign lu = hz.ex_is_load & hz.ex_reg_wr & (hz.ex_rd != X0) &
              (src_hit(hz.id_rs1_used, hz.id_rs1, hz.ex_rd) |
               src_hit(hz.id_rs2_used, hz.id_rs2, hz.ex_rd));

  assign mdu_stall = ((state == RUN) & hz.ex_mdu_start) |
                     ((state == MDU_BUSY) & (mcnt != '0));

  // State register plus counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      mcnt  <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      mcnt  <= mcnt_nx;
      wcnt  <= mw ? wcnt + 8'd1 : '0;
    end
  end

  // Next state. The MDU countdown keeps running under a memory wait, but
  // the op is not retired until the wait drops.
  always_comb begin
    state_nx = state;
    mcnt_nx  = mcnt;
    case (state)
      RUN: begin
        if (hz.ex_mdu_start) begin
          state_nx = MDU_BUSY;
          mcnt_nx  = MCNT_START;
        end
      end
      MDU_BUSY: begin
        if (mcnt != '0)
          mcnt_nx = mcnt - 5'd1;
        else if (!mw)
          state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // Outputs, priority mw > MDU > redirect > load-use.
  always_comb begin
    stall_ex_i = mw | mdu_stall;
    redir_act  = hz.ex_redirect & ~stall_ex_i;
    lu_act     = lu & ~stall_ex_i & ~hz.ex_redirect;

    hz.stall_if  = stall_ex_i | lu_act;
    hz.stall_id  = stall_ex_i | lu_act;
    hz.stall_ex  = stall_ex_i;
    hz.stall_mem = mw;
    hz.flush_if  = redir_act;
    hz.flush_id  = redir_act;
    hz.flush_ex  = lu_act;
    hz.mdu_done  = (state == MDU_BUSY) & (mcnt == '0) & ~mw;
    hz.mem_err   = tout;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios and randomized
// traffic on two configurations, checked against a cycle-level model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] rs1, rs2, rd;
  logic u1, u2, reg_wr, is_load, redirect, mdu_start, req, ack;

  hazard_ctrl_if ifa ();
  hazard_ctrl_if ifb ();

  assign ifa.id_rs1 = rs1;         assign ifb.id_rs1 = rs1;
  assign ifa.id_rs2 = rs2;         assign ifb.id_rs2 = rs2;
  assign ifa.id_rs1_used = u1;     assign ifb.id_rs1_used = u1;
  assign ifa.id_rs2_used = u2;     assign ifb.id_rs2_used = u2;
  assign ifa.ex_rd = rd;           assign ifb.ex_rd = rd;
  assign ifa.ex_reg_wr = reg_wr;   assign ifb.ex_reg_wr = reg_wr;
  assign ifa.ex_is_load = is_load; assign ifb.ex_is_load = is_load;
  assign ifa.ex_redirect = redirect;   assign ifb.ex_redirect = redirect;
  assign ifa.ex_mdu_start = mdu_start; assign ifb.ex_mdu_start = mdu_start;
  assign ifa.mem_req = req;        assign ifb.mem_req = req;
  assign ifa.mem_ack = ack;        assign ifb.mem_ack = ack;

  hazard_ctrl #(.MDU_LAT(4), .MEM_TIMEOUT(16)) dut_a (.clk(clk), .reset(reset), .hz(ifa.slave));
  hazard_ctrl #(.MDU_LAT(2), .MEM_TIMEOUT(4))  dut_b (.clk(clk), .reset(reset), .hz(ifb.slave));

  // {stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id, flush_ex, mdu_done, mem_err}
  wire [8:0] oa = {ifa.stall_if, ifa.stall_id, ifa.stall_ex, ifa.stall_mem,
                   ifa.flush_if, ifa.flush_id, ifa.flush_ex, ifa.mdu_done, ifa.mem_err};
  wire [8:0] ob = {ifb.stall_if, ifb.stall_id, ifb.stall_ex, ifb.stall_mem,
                   ifb.flush_if, ifb.flush_id, ifb.flush_ex, ifb.mdu_done, ifb.mem_err};

  int ntests = 0;
  int nfail  = 0;

  // Model: MDU tracked as cycles elapsed since the op entered EX; memory as
  // cycles spent waiting.
  int lat [2] = '{4, 2};
  int tmo [2] = '{16, 4};
  bit act [2];
  int elapsed [2];
  int waited [2];
  logic [8:0] got_a, got_b;

  task automatic chk(string tag, logic [8:0] got, logic [8:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; elapsed[d] = 0; waited[d] = 0;
    end
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; reg_wr = 0; is_load = 0;
    redirect = 0; mdu_start = 0; req = 0; ack = 0;
  endtask

  // One cycle: sample at negedge, compare both DUTs with the model, advance.
  task automatic step(string tag);
    bit tout, mw, mst, done, sex, red, lua, luh;
    logic [8:0] exp;
    @(negedge clk);
    got_a = oa; got_b = ob;
    luh = is_load && reg_wr && (rd != 0) &&
          ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    for (int d = 0; d < 2; d++) begin
      tout = (waited[d] == tmo[d]);
      mw   = req && !ack && !tout;
      mst  = act[d] ? (elapsed[d] < lat[d] - 1) : mdu_start;
      done = act[d] && (elapsed[d] >= lat[d] - 1) && !mw;
      sex  = mw || mst;
      red  = redirect && !sex;
      lua  = luh && !sex && !redirect;
      exp  = {sex || lua, sex || lua, sex, mw, red, red, lua, done, tout};
      chk($sformatf("%s/cfg%0d", tag, d), (d == 0) ? got_a : got_b, exp);
      waited[d] = mw ? waited[d] + 1 : 0;
      if (!act[d]) begin
        if (mdu_start) begin act[d] = 1; elapsed[d] = 1; end
      end else if (done) act[d] = 0;
      else elapsed[d]++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  int cnt;

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_clear();

    step("reset_idle");
    chk("reset_zero", got_a, 9'b0);

    // Load-use hit, then the same with x0 as destination.
    is_load = 1; reg_wr = 1; rd = 5; rs1 = 5; u1 = 1;
    step("lu");
    chk("lu_bubble", got_a, 9'b110000100);
    rd = 0; rs1 = 0;
    step("lu_x0");
    chk("lu_x0_none", got_a, 9'b0);
    idle();
    step("lu_after");

    // Redirect alone and together with a load-use hit.
    redirect = 1;
    step("redir");
    chk("redir_flush", got_a, 9'b000011000);
    is_load = 1; reg_wr = 1; rd = 7; rs2 = 7; u2 = 1;
    step("redir_lu");
    chk("redir_beats_lu", got_a, 9'b000011000);
    idle();
    step("redir_after");

    // MDU op on MDU_LAT=4: start held for the whole occupancy.
    cnt = 0;
    mdu_start = 1;
    for (int i = 0; i < 4; i++) begin
      step("mdu4");
      if (got_a[6]) cnt++;
    end
    chk("mdu4_stall_cycles", 9'(cnt), 9'd3);
    chk("mdu4_done_last", {8'd0, got_a[1]}, 9'd1);
    mdu_start = 0;
    step("mdu4_after");

    // MDU op on MDU_LAT=2.
    cnt = 0;
    mdu_start = 1;
    for (int i = 0; i < 2; i++) begin
      step("mdu2");
      if (got_b[6]) cnt++;
    end
    chk("mdu2_stall_cycles", 9'(cnt), 9'd1);
    chk("mdu2_done_last", {8'd0, got_b[1]}, 9'd1);
    mdu_start = 0;
    for (int i = 0; i < 3; i++) step("mdu2_drain");

    // Memory wait of 3 cycles, then ack.
    cnt = 0;
    req = 1;
    for (int i = 0; i < 3; i++) begin
      step("mw3");
      if (got_a[8:5] == 4'hF) cnt++;
    end
    chk("mw3_stall_cycles", 9'(cnt), 9'd3);
    ack = 1;
    step("mw3_ack");
    chk("mw3_ack_nostall", got_a, 9'b0);
    idle();
    step("mw3_after");

    // Same-cycle ack never stalls.
    req = 1; ack = 1;
    step("ack_same");
    chk("ack_same_nostall", got_a, 9'b0);
    idle();

    // No ack: error pulse on cycle 17 with stalls released.
    cnt = 0;
    req = 1;
    for (int i = 0; i < 16; i++) begin
      step("tout_wait");
      if (got_a[0]) cnt++;
    end
    step("tout_hit");
    chk("tout_err_cycle", got_a, 9'b000000001);
    chk("tout_no_early_err", 9'(cnt), 9'd0);
    idle();
    step("tout_after");
    step("tout_after2");

    // Overlap: wait starts in the last MDU cycle; redirect under stall ignored.
    mdu_start = 1;
    step("ov_c1");
    mdu_start = 0; redirect = 1;
    step("ov_c2");
    chk("ov_redir_ignored", {7'd0, got_a[4:3]}, 9'd0);
    redirect = 0;
    step("ov_c3");
    req = 1;
    step("ov_c4_wait");
    chk("ov_done_delayed", {8'd0, got_a[1]}, 9'd0);
    step("ov_c5_wait");
    ack = 1;
    step("ov_ack");
    chk("ov_done_after_wait", got_a, 9'b000000010);
    idle();
    step("ov_after");

    // Reset in cycle 2 of an MDU op.
    mdu_start = 1;
    step("rst_c1");
    mdu_start = 0;
    do_reset();
    step("rst_after");
    chk("rst_mid_mdu", got_a, 9'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1 = 1'($urandom); u2 = 1'($urandom);
      reg_wr = 1'($urandom); is_load = 1'($urandom);
      redirect = ($urandom_range(0, 5) == 0);
      mdu_start = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 3) == 0) req = ~req;
      ack = req && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        req = 0;
      end else
        step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
